// File: rtl/riscv_run_monitor_if.sv
// riscv_run_monitor_if: core-side stimulus and run status/statistics bundle for the run monitor
interface riscv_run_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             run_en;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  alu_res;
  logic             core_reset;
  logic             running;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [XLEN-1:0]  halt_pc;
  logic [XLEN-1:0]  halt_res;
  modport master (
    output run_en, pc, alu_res,
    input  core_reset, running, done, pass, fail, timeout, cycle_count, halt_pc, halt_res
  );
  modport slave (
    input  run_en, pc, alu_res,
    output core_reset, running, done, pass, fail, timeout, cycle_count, halt_pc, halt_res
  );
endinterface

// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: holds the core in reset, then counts run cycles and classifies the
// end of the program (self-loop at pass/fail address, or timeout).
module riscv_run_monitor #(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter int              RST_CYCLES  = 2,
  parameter int              MAX_CYCLES  = 500,
  parameter int              HALT_STABLE = 4,
  parameter logic [XLEN-1:0] PASS_ADDR   = XLEN'(32'h0000_0040)
) (
  input logic clk,
  input logic reset_n,
  riscv_run_monitor_if.slave bus
);
  localparam int SW = $clog2(HALT_STABLE + 1);
  localparam logic [CNT_W-1:0] RSTC = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CYCLES);
  typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, r_cycle_cnt, w_cycle_nxt, w_hold_nxt;
  logic [SW-1:0]    r_stable, w_stable_nxt;
  logic [XLEN-1:0]  r_pc_prev, r_halt_pc, r_halt_res;
  logic             w_step, w_halt, w_tmo;
  // r_stable == 0 marks the first run cycle, where there is no previous pc to compare
  always_comb begin
    w_step       = (r_state == S_RUN) && bus.run_en;
    w_hold_nxt   = r_hold_cnt + 1'b1;
    w_cycle_nxt  = &r_cycle_cnt ? r_cycle_cnt : r_cycle_cnt + 1'b1;
    w_stable_nxt = (r_stable != '0 && bus.pc == r_pc_prev) ? r_stable + 1'b1 : SW'(1);
    w_halt       = w_step && (w_stable_nxt == SW'(HALT_STABLE));
    w_tmo        = w_step && !w_halt && (w_cycle_nxt == MAXC);
    w_state_nxt  = r_state;
    if (r_state == S_HOLD && w_hold_nxt == RSTC) w_state_nxt = S_RUN;
    else if (w_halt) w_state_nxt = (bus.pc == PASS_ADDR) ? S_PASS : S_FAIL;
    else if (w_tmo) w_state_nxt = S_TMO;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_stable    <= '0;
      r_pc_prev   <= '0;
      r_halt_pc   <= '0;
      r_halt_res  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_HOLD) r_hold_cnt <= w_hold_nxt;
      if (w_step) begin
        r_cycle_cnt <= w_cycle_nxt;
        r_stable    <= w_stable_nxt;
        r_pc_prev   <= bus.pc;
      end
      if (w_halt || w_tmo) begin
        r_halt_pc  <= bus.pc;
        r_halt_res <= w_halt ? bus.alu_res : '0;
      end
    end
  end
  assign bus.core_reset  = (r_state == S_HOLD);
  assign bus.running     = (r_state == S_RUN);
  assign bus.pass        = (r_state == S_PASS);
  assign bus.fail        = (r_state == S_FAIL);
  assign bus.timeout     = (r_state == S_TMO);
  assign bus.done        = bus.pass || bus.fail || bus.timeout;
  assign bus.cycle_count = r_cycle_cnt;
  assign bus.halt_pc     = r_halt_pc;
  assign bus.halt_res    = r_halt_res;
endmodule

// File: tb/tb_riscv_run_monitor.sv
// tb_riscv_run_monitor: directed vectors for reset hold, pass/fail/timeout verdicts,
// halt-vs-timeout priority, run_en freeze and asynchronous mid-run reset.
module tb_riscv_run_monitor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  riscv_run_monitor_if #(.XLEN(32), .CNT_W(32)) ifc ();
  riscv_run_monitor dut (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // inputs change on the falling edge; outputs are checked on the falling edge after
  task automatic step(input logic [31:0] p, input logic [31:0] a);
    ifc.pc = p;
    ifc.alu_res = a;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    ifc.run_en = 1'b1;
    ifc.pc = '0;
    ifc.alu_res = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_core_reset", ifc.core_reset, 1);
    check("rst_flags", {ifc.running, ifc.done, ifc.pass, ifc.fail, ifc.timeout}, 0);
    check("rst_cycles", ifc.cycle_count, 0);
    step(32'hFFFF_FFF0, 0);
    check("hold_edge1_core_reset", ifc.core_reset, 1);
    check("hold_edge1_running", ifc.running, 0);
    step(32'hFFFF_FFF0, 0);
    check("hold_edge2_core_reset", ifc.core_reset, 0);
    check("hold_edge2_running", ifc.running, 1);
  endtask
  initial begin
    ifc.run_en = 1'b1;
    ifc.pc = '0;
    ifc.alu_res = '0;
    // pass: pc steps from 0, loops at 0x40 from run cycle 17
    do_reset();
    for (int k = 1; k <= 19; k++) step(k < 17 ? 32'(4 * (k - 1)) : 32'h40, 32'h1000 + 32'(k));
    check("pass_not_yet_done", ifc.done, 0);
    step(32'h40, 32'h1000 + 20);
    check("pass_flag", ifc.pass, 1);
    check("pass_done", ifc.done, 1);
    check("pass_running", ifc.running, 0);
    check("pass_halt_pc", ifc.halt_pc, 32'h40);
    check("pass_cycles", ifc.cycle_count, 20);
    check("pass_halt_res", ifc.halt_res, 32'h1000 + 20);
    for (int k = 0; k < 3; k++) step(32'h40, 32'hDEAD);
    check("pass_sticky", {ifc.pass, ifc.core_reset}, 2'b10);
    check("pass_cycles_frozen", ifc.cycle_count, 20);
    // fail: loop at 0x3C from run cycle 16, detected at 19
    do_reset();
    for (int k = 1; k <= 19; k++) step(k < 16 ? 32'(4 * (k - 1)) : 32'h3C, 32'hA5A5_0000 + 32'(k));
    check("fail_flag", {ifc.fail, ifc.pass, ifc.timeout}, 3'b100);
    check("fail_halt_pc", ifc.halt_pc, 32'h3C);
    check("fail_halt_res", ifc.halt_res, 32'hA5A5_0013);
    check("fail_cycles", ifc.cycle_count, 19);
    // timeout: pc never repeats
    do_reset();
    for (int k = 1; k <= 499; k++) step(32'(4 * k), 32'h77);
    check("tmo_not_yet", {ifc.timeout, ifc.running}, 2'b01);
    step(32'(4 * 500), 32'h77);
    check("tmo_flag", {ifc.timeout, ifc.done, ifc.pass, ifc.fail}, 4'b1100);
    check("tmo_cycles", ifc.cycle_count, 500);
    check("tmo_halt_pc", ifc.halt_pc, 32'h7D0);
    check("tmo_halt_res", ifc.halt_res, 0);
    // halt detected on the same edge as cycle 500
    do_reset();
    for (int k = 1; k <= 500; k++) step(k < 497 ? 32'(4 * k) : 32'h40, 32'h55);
    check("tie_pass_wins", {ifc.pass, ifc.timeout}, 2'b10);
    check("tie_cycles", ifc.cycle_count, 500);
    check("tie_halt_res", ifc.halt_res, 32'h55);
    // run_en freeze, then asynchronous reset mid-run
    do_reset();
    for (int k = 1; k <= 5; k++) step(32'(4 * k), 0);
    check("frz_before", ifc.cycle_count, 5);
    ifc.run_en = 1'b0;
    for (int k = 0; k < 10; k++) step(32'h40, 0);
    check("frz_cycles", ifc.cycle_count, 5);
    check("frz_state", {ifc.running, ifc.done, ifc.core_reset}, 3'b100);
    ifc.run_en = 1'b1;
    for (int k = 1; k <= 3; k++) step(32'h100 + 32'(4 * k), 0);
    check("frz_resume", ifc.cycle_count, 8);
    #2 reset_n = 1'b0;
    #1;
    check("async_core_reset", ifc.core_reset, 1);
    check("async_flags", {ifc.running, ifc.done, ifc.pass, ifc.fail, ifc.timeout}, 0);
    check("async_cycles", ifc.cycle_count, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
